// File: rtl/tdm_mux_8to1.sv
// Time-division transmitter: captures eight channel words on start and sends
// one slot per cycle on y, with a matching slot index s for a 1:8 demux.
module tdm_mux_8to1 #(
  parameter int DATA_W = 1,
  parameter int NCH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NCH*DATA_W-1:0] d,
  input  logic                  hold,
  output logic [DATA_W-1:0]     y,
  output logic [2:0]            s,
  output logic                  valid,
  output logic                  sof,
  output logic                  busy,
  output logic                  done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]            state_q,  state_d;
  logic [NCH*DATA_W-1:0] shadow_q, shadow_d;
  logic [2:0]            slot_q,   slot_d;
  logic                  wrap_q,   wrap_d;
  logic [DATA_W-1:0]     y_q,      y_d;
  logic [2:0]            s_q,      s_d;
  logic                  valid_q,  valid_d;
  logic                  sof_q,    sof_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;

  logic [DATA_W-1:0] shadow_word [NCH];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_word
      assign shadow_word[gi] = shadow_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    slot_d   = slot_q;
    wrap_d   = wrap_q;
    y_d      = y_q;
    s_d      = s_q;
    valid_d  = valid_q;
    sof_d    = sof_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        sof_d   = 1'b0;
        busy_d  = 1'b0;
        if (start) begin
          shadow_d = d;
          slot_d   = 3'd0;
          wrap_d   = 1'b0;
          state_d  = ST_SEND;
          busy_d   = 1'b1;
        end
      end
      ST_SEND: begin
        if (hold) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
        end else if (wrap_q) begin
          // Frame boundary: a start here chains the next frame with no gap.
          done_d = 1'b1;
          wrap_d = 1'b0;
          slot_d = 3'd0;
          if (start) begin
            shadow_d = d;
            y_d      = d[DATA_W-1:0];
            s_d      = 3'd0;
            valid_d  = 1'b1;
            sof_d    = 1'b1;
            slot_d   = 3'd1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
          end
        end else begin
          y_d     = shadow_word[slot_q];
          s_d     = slot_q;
          valid_d = 1'b1;
          sof_d   = (slot_q == 3'd0);
          slot_d  = slot_q + 3'd1;
          wrap_d  = (slot_q == 3'd7);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      slot_q   <= 3'd0;
      wrap_q   <= 1'b0;
      y_q      <= '0;
      s_q      <= 3'd0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      wrap_q   <= wrap_d;
      y_q      <= y_d;
      s_q      <= s_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign y     = y_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign sof   = sof_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// Scoreboard bench for tdm_mux_8to1: expected slots are queued at start and
// matched against slots observed on valid, plus a demux loopback check.
module tb_tdm_mux_8to1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] d = 8'h00;
  logic       hold = 1'b0;
  logic [0:0] y;
  logic [2:0] s;
  logic       valid, sof, busy, done;

  typedef logic [4:0] ent_t;  // {sof, s, y}

  ent_t exp_q[$];
  ent_t obs_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc, first_valid, last_valid, valid_cnt, done_cnt, done_cyc, busy_low_cnt;
  logic done_busy;
  logic [7:0] demux_out;
  logic [7:0] loop_cap;
  logic       timed_out;

  tdm_mux_8to1 #(.DATA_W(1), .NCH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .d(d), .hold(hold),
    .y(y), .s(s), .valid(valid), .sof(sof), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural 1:8 demux on the y/s line.
  always_comb begin
    demux_out    = 8'h00;
    demux_out[s] = y[0];
  end

  task automatic clear_stats();
    exp_q.delete();
    obs_q.delete();
    cyc = 0; first_valid = -1; last_valid = -1; valid_cnt = 0;
    done_cnt = 0; done_cyc = -1; busy_low_cnt = 0; done_busy = 1'b1;
  endtask

  task automatic push_frame(input logic [7:0] dv);
    for (int k = 0; k < 8; k++)
      exp_q.push_back({(k == 0), 3'(k), dv[k]});
  endtask

  // One clock; observe outputs 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      obs_q.push_back({sof, s, y[0]});
      if (first_valid < 0) first_valid = cyc;
      last_valid = cyc;
      valid_cnt++;
      loop_cap[s] = demux_out[s];
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_busy = busy;
    end
    if (!busy) busy_low_cnt++;
  endtask

  task automatic run_to_done(input int bound, input int target, output logic to);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      step();
      n++;
    end
    to = (done_cnt < target);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({y, s, valid, sof, busy, done} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs got %b required 00000000", {y, s, valid, sof, busy, done});
    end
    @(negedge clk) rst_n = 1'b1;
    clear_stats();
    repeat (2) step();
    n_checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy=%b valid=%b required 0 0", busy, valid);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    ent_t e, o;
    clear_stats();
    push_frame(8'b1010_0110);
    d = 8'b1010_0110; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL capture_cycle busy=%b valid=%b required 1 0", busy, valid);
    end
    run_to_done(20, 1, timed_out);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout done_cnt=%0d required 1", done_cnt); end
    n_checks++;
    if (first_valid !== 2) begin n_fail++; $display("FAIL basic_latency first_valid_cyc=%0d required 2", first_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL basic_slot missing required %b", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL basic_slot got %b required %b", o, e); end
      end
    end
    n_checks++;
    if (valid_cnt != 8 || last_valid - first_valid != 7) begin
      n_fail++;
      $display("FAIL basic_contiguous valid_cnt=%0d span=%0d required 8 7", valid_cnt, last_valid - first_valid);
    end
    n_checks++;
    if (done_cyc != last_valid + 1 || done_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done done_cyc=%0d busy=%b required %0d 0", done_cyc, done_busy, last_valid + 1);
    end
    step();
    n_checks++;
    if (done_cnt != 1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse done_cnt=%0d valid=%b required 1 0", done_cnt, valid);
    end
    $display("test_basic frame d=%b slots=%0d", 8'b1010_0110, valid_cnt);
  endtask

  task automatic test_shadow();
    ent_t e, o;
    clear_stats();
    push_frame(8'h00);
    d = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    d = 8'hFF;
    run_to_done(20, 1, timed_out);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL shadow_timeout done_cnt=%0d required 1", done_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL shadow_slot missing required %b", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL shadow_slot got %b required %b", o, e); end
      end
    end
    $display("test_shadow frame slots=%0d", valid_cnt);
  endtask

  task automatic test_hold();
    ent_t e, o;
    clear_stats();
    push_frame(8'h5C);
    d = 8'h5C; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    n_checks++;
    if (valid !== 1'b1 || s !== 3'd3) begin n_fail++; $display("FAIL hold_pre valid=%b s=%0d required 1 3", valid, s); end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (valid !== 1'b0 || s !== 3'd3 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_stall valid=%b s=%0d busy=%b required 0 3 1", valid, s, busy);
      end
    end
    hold = 1'b0;
    step();
    n_checks++;
    if (valid !== 1'b1 || s !== 3'd4) begin n_fail++; $display("FAIL hold_release valid=%b s=%0d required 1 4", valid, s); end
    run_to_done(20, 1, timed_out);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL hold_timeout done_cnt=%0d required 1", done_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL hold_slot missing required %b", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL hold_slot got %b required %b", o, e); end
      end
    end
    n_checks++;
    if (valid_cnt != 8) begin n_fail++; $display("FAIL hold_count got %0d required 8", valid_cnt); end
    $display("test_hold frame slots=%0d", valid_cnt);
  endtask

  task automatic test_back_to_back();
    ent_t e, o;
    clear_stats();
    push_frame(8'h0F);
    push_frame(8'hF0);
    d = 8'h0F; start = 1'b1;
    step();
    d = 8'hF0;
    repeat (8) step();
    step();
    n_checks++;
    if ({done, sof, valid, busy} !== 4'b1111 || s !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_boundary done/sof/valid/busy=%b s=%0d required 1111 0", {done, sof, valid, busy}, s);
    end
    start = 1'b0;
    run_to_done(20, 2, timed_out);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL b2b_timeout done_cnt=%0d required 2", done_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_slot missing required %b", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL b2b_slot got %b required %b", o, e); end
      end
    end
    n_checks++;
    if (valid_cnt != 16 || last_valid - first_valid != 15 || busy_low_cnt != 1) begin
      n_fail++;
      $display("FAIL b2b_gapless valid_cnt=%0d span=%0d busy_low=%0d required 16 15 1",
               valid_cnt, last_valid - first_valid, busy_low_cnt);
    end
    $display("test_back_to_back frames=2 slots=%0d", valid_cnt);
  endtask

  task automatic test_reset_mid();
    ent_t e, o;
    logic [7:0] dv;
    clear_stats();
    d = 8'($urandom); start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    n_checks++;
    if (valid !== 1'b1 || s !== 3'd5) begin n_fail++; $display("FAIL rstmid_pre valid=%b s=%0d required 1 5", valid, s); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({y, s, valid, sof, busy, done} !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_async got %b required 00000000", {y, s, valid, sof, busy, done});
    end
    repeat (3) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_done done_cnt=%0d busy=%b valid=%b required 0 0 0", done_cnt, busy, valid);
    end
    clear_stats();
    dv = 8'($urandom);
    push_frame(dv);
    d = dv; start = 1'b1;
    step();
    start = 1'b0;
    run_to_done(20, 1, timed_out);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL rstmid_timeout done_cnt=%0d required 1", done_cnt); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL rstmid_slot missing required %b", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL rstmid_slot got %b required %b", o, e); end
      end
    end
    $display("test_reset_mid restart frame d=%b slots=%0d", dv, valid_cnt);
  endtask

  task automatic test_loopback();
    logic [7:0] dv;
    for (int f = 0; f < 16; f++) begin
      clear_stats();
      dv = 8'($urandom);
      loop_cap = ~dv;
      d = dv; start = 1'b1;
      step();
      start = 1'b0;
      run_to_done(20, 1, timed_out);
      n_checks++;
      if (timed_out) begin n_fail++; $display("FAIL loop_timeout frame=%0d done_cnt=%0d required 1", f, done_cnt); end
      n_checks++;
      if (loop_cap !== dv || valid_cnt != 8) begin
        n_fail++;
        $display("FAIL loop_channels frame=%0d got %b slots=%0d required %b 8", f, loop_cap, valid_cnt, dv);
      end
      $display("test_loopback frame=%0d d=%b demux=%b", f, dv, loop_cap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
